// File: rtl/multi_pwm_controller.sv
// rtl/multi_pwm_controller.sv - N-channel PWM generator with double-buffered duty/mode and phase stagger
module multi_pwm_controller #(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 8,
    parameter int PHASE_STAGGER = 1
) (
    input  logic                    clk_pwm,
    input  logic                    rst_n,
    input  logic                    sleep,
    input  logic                    load,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic [2*NUM_CH-1:0]     mode_in,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    update_pending
);

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_ON  = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;
    localparam logic [1:0] MODE_INV = 2'b11;

    localparam longint          PERIOD  = longint'(1) << WIDTH;
    localparam longint          STEP    = PERIOD / NUM_CH;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [WIDTH-1:0] ch_offset(input int idx);
        longint prod;
        prod = longint'(idx) * STEP;
        if (PHASE_STAGGER == 0) begin
            return '0;
        end
        return prod[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [NUM_CH*WIDTH-1:0] act_duty_q, act_duty_d;
    logic [2*NUM_CH-1:0]     sh_mode_q, sh_mode_d;
    logic [2*NUM_CH-1:0]     act_mode_q, act_mode_d;
    logic                    pend_q, pend_d;
    logic                    ps_q, ps_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic [NUM_CH-1:0]       ch_level;
    logic                    commit;

    // Per-channel phase compare; the offset add wraps in WIDTH bits by construction.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [WIDTH-1:0] OFFSET = ch_offset(g);

        logic [WIDTH-1:0] phase;
        logic [1:0]       mode;
        logic             raw;

        assign phase = cnt_q + OFFSET;
        assign mode  = act_mode_q[2*g +: 2];
        assign raw   = (phase < act_duty_q[g*WIDTH +: WIDTH]);

        assign ch_level[g] = (mode == MODE_ON)  ? 1'b1 :
                             (mode == MODE_PWM) ? raw  :
                             (mode == MODE_INV) ? ~raw :
                                                  1'b0;
    end

    // While dark there is no glitch risk, so a pending update commits straight away.
    assign commit = sleep ? pend_q : (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d      = cnt_q;
        sh_duty_d  = sh_duty_q;
        sh_mode_d  = sh_mode_q;
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        pend_d     = pend_q;
        ps_d       = 1'b0;
        pwm_d      = '0;

        if (sleep) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            ps_d  = (cnt_q == '0);
            pwm_d = ch_level;
        end

        if (commit) begin
            act_duty_d = sh_duty_q;
            act_mode_d = sh_mode_q;
            pend_d     = 1'b0;
        end

        // A load on the commit edge lands in the shadow and keeps the update pending.
        if (load) begin
            sh_duty_d = duty_in;
            sh_mode_d = mode_in;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_pwm or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sh_duty_q  <= '0;
            sh_mode_q  <= {NUM_CH{MODE_OFF}};
            act_duty_q <= '0;
            act_mode_q <= {NUM_CH{MODE_OFF}};
            pend_q     <= 1'b0;
            ps_q       <= 1'b0;
            pwm_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            pend_q     <= pend_d;
            ps_q       <= ps_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_start   = ps_q;
    assign update_pending = pend_q;

endmodule

// File: tb/tb_multi_pwm_controller.sv
// tb/tb_multi_pwm_controller.sv - directed self-checking bench for multi_pwm_controller
module tb_multi_pwm_controller;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_ON  = 2'b01;
    localparam logic [1:0] M_PWM = 2'b10;
    localparam logic [1:0] M_INV = 2'b11;

    logic                    clk_pwm = 1'b0;
    logic                    rst_n   = 1'b0;
    logic                    sleep   = 1'b0;
    logic                    load    = 1'b0;
    logic [NUM_CH*WIDTH-1:0] duty_in = '0;
    logic [2*NUM_CH-1:0]     mode_in = '0;
    logic [NUM_CH-1:0]       pwm_a, pwm_s;
    logic                    ps_a, ps_s, pend_a, pend_s;

    int n_chk  = 0;
    int n_fail = 0;
    int mcnt   = 0;
    int hi[NUM_CH];
    int rise[NUM_CH];
    int ps_n, pend_n, overlap;

    multi_pwm_controller #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PHASE_STAGGER(0)) u_aligned (
        .clk_pwm(clk_pwm), .rst_n(rst_n), .sleep(sleep), .load(load),
        .duty_in(duty_in), .mode_in(mode_in),
        .pwm_out(pwm_a), .period_start(ps_a), .update_pending(pend_a)
    );

    multi_pwm_controller #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PHASE_STAGGER(1)) u_stagger (
        .clk_pwm(clk_pwm), .rst_n(rst_n), .sleep(sleep), .load(load),
        .duty_in(duty_in), .mode_in(mode_in),
        .pwm_out(pwm_s), .period_start(ps_s), .update_pending(pend_s)
    );

    always #5 clk_pwm = ~clk_pwm;

    // Reference period counter: the value the next rising edge will sample.
    always @(posedge clk_pwm or negedge rst_n) begin
        if (!rst_n)     mcnt <= 0;
        else if (sleep) mcnt <= 0;
        else            mcnt <= (mcnt + 1) % 256;
    end

    task automatic tick();
        @(posedge clk_pwm);
        #1;
    endtask

    task automatic set_ch(input int ch, input int duty, input logic [1:0] mode);
        duty_in[ch*WIDTH +: WIDTH] = WIDTH'(duty);
        mode_in[2*ch +: 2]         = mode;
    endtask

    task automatic pulse_load();
        if (mcnt == 255) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int budget = 1000;
        while (mcnt != target && budget > 0) begin
            tick();
            budget--;
        end
        if (mcnt != target) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_cnt: counter %0d never reached %0d", mcnt, target);
        end
    endtask

    // Observes one whole period (samples for cnt=0..255); optional load at cnt==ld_at.
    task automatic measure(input bit stag, input int ld_at);
        logic [NUM_CH-1:0] cur, prev;
        wait_cnt(0);
        prev = stag ? pwm_s : pwm_a;
        for (int c = 0; c < NUM_CH; c++) begin
            hi[c]   = 0;
            rise[c] = -1;
        end
        ps_n = 0; pend_n = 0; overlap = 0;
        for (int s = 0; s < 256; s++) begin
            tick();
            load = 1'b0;
            cur = stag ? pwm_s : pwm_a;
            for (int c = 0; c < NUM_CH; c++) begin
                if (cur[c]) hi[c]++;
                if (cur[c] && !prev[c] && rise[c] < 0) rise[c] = s;
            end
            if ($countones(cur) > 1) overlap++;
            if (stag ? ps_s : ps_a) ps_n++;
            if (pend_a) pend_n++;
            prev = cur;
            if (ld_at == s + 1) load = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (pwm_a !== 4'h0) begin n_fail++; $display("FAIL reset_pwm_a: got %h expected 0", pwm_a); end
        n_chk++; if (pwm_s !== 4'h0) begin n_fail++; $display("FAIL reset_pwm_s: got %h expected 0", pwm_s); end
        n_chk++; if (ps_a !== 1'b0 || ps_s !== 1'b0) begin n_fail++; $display("FAIL reset_period_start: got %b%b expected 00", ps_a, ps_s); end
        n_chk++; if (pend_a !== 1'b0 || pend_s !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b%b expected 00", pend_a, pend_s); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_ch(0, 64, M_PWM);
        pulse_load();
        n_chk++; if (pend_a !== 1'b1) begin n_fail++; $display("FAIL basic_pend_after_load: got %b expected 1", pend_a); end
        wait_cnt(255);
        n_chk++; if (pend_a !== 1'b1) begin n_fail++; $display("FAIL basic_pend_before_wrap: got %b expected 1", pend_a); end
        tick();
        n_chk++; if (pend_a !== 1'b0) begin n_fail++; $display("FAIL basic_pend_after_wrap: got %b expected 0", pend_a); end
        for (int p = 0; p < 2; p++) begin
            measure(1'b0, -1);
            n_chk++; if (hi[0] !== 64) begin n_fail++; $display("FAIL basic_ch0_high p%0d: got %0d expected 64", p, hi[0]); end
            n_chk++; if (hi[1] !== 0) begin n_fail++; $display("FAIL basic_ch1_off p%0d: got %0d expected 0", p, hi[1]); end
            n_chk++; if (ps_n !== 1) begin n_fail++; $display("FAIL basic_period_start p%0d: got %0d expected 1", p, ps_n); end
        end
    endtask

    task automatic test_boundaries();
        set_ch(0, 0, M_PWM);
        set_ch(1, 255, M_PWM);
        set_ch(2, 17, M_ON);
        set_ch(3, 64, M_INV);
        pulse_load();
        measure(1'b0, -1);
        n_chk++; if (hi[0] !== 0)   begin n_fail++; $display("FAIL bound_duty0: got %0d expected 0", hi[0]); end
        n_chk++; if (hi[1] !== 255) begin n_fail++; $display("FAIL bound_duty255: got %0d expected 255", hi[1]); end
        n_chk++; if (hi[2] !== 256) begin n_fail++; $display("FAIL bound_mode_on: got %0d expected 256", hi[2]); end
        n_chk++; if (hi[3] !== 192) begin n_fail++; $display("FAIL bound_inv64: got %0d expected 192", hi[3]); end
    endtask

    task automatic test_glitch_free();
        set_ch(0, 0, M_OFF);
        set_ch(1, 200, M_PWM);
        set_ch(2, 0, M_OFF);
        set_ch(3, 0, M_OFF);
        pulse_load();
        measure(1'b0, -1);
        n_chk++; if (hi[1] !== 200) begin n_fail++; $display("FAIL glitch_initial: got %0d expected 200", hi[1]); end
        set_ch(1, 10, M_PWM);
        measure(1'b0, 100);
        n_chk++; if (hi[1] !== 200) begin n_fail++; $display("FAIL glitch_current_period: got %0d expected 200", hi[1]); end
        n_chk++; if (pend_n !== 155) begin n_fail++; $display("FAIL glitch_pending_span: got %0d expected 155", pend_n); end
        measure(1'b0, -1);
        n_chk++; if (hi[1] !== 10) begin n_fail++; $display("FAIL glitch_next_period: got %0d expected 10", hi[1]); end
    endtask

    task automatic test_back_to_back();
        set_ch(1, 30, M_PWM);
        wait_cnt(10);
        pulse_load();
        set_ch(1, 90, M_PWM);
        wait_cnt(255);
        load = 1'b1;
        tick();
        load = 1'b0;
        n_chk++; if (pend_a !== 1'b1) begin n_fail++; $display("FAIL b2b_pend_after_commit_load: got %b expected 1", pend_a); end
        measure(1'b0, -1);
        n_chk++; if (hi[1] !== 30)   begin n_fail++; $display("FAIL b2b_period_a: got %0d expected 30", hi[1]); end
        n_chk++; if (pend_n !== 255) begin n_fail++; $display("FAIL b2b_pend_span: got %0d expected 255", pend_n); end
        measure(1'b0, -1);
        n_chk++; if (hi[1] !== 90) begin n_fail++; $display("FAIL b2b_period_b: got %0d expected 90", hi[1]); end
        n_chk++; if (pend_n !== 0) begin n_fail++; $display("FAIL b2b_pend_clear: got %0d expected 0", pend_n); end
    endtask

    task automatic test_stagger();
        int exp_rise[NUM_CH] = '{0, 192, 128, 64};
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 64, M_PWM);
        pulse_load();
        measure(1'b1, -1);
        for (int c = 0; c < NUM_CH; c++) begin
            n_chk++; if (hi[c] !== 64) begin n_fail++; $display("FAIL stagger_high ch%0d: got %0d expected 64", c, hi[c]); end
            n_chk++; if (rise[c] !== exp_rise[c]) begin n_fail++; $display("FAIL stagger_rise ch%0d: got %0d expected %0d", c, rise[c], exp_rise[c]); end
        end
        n_chk++; if (overlap !== 0) begin n_fail++; $display("FAIL stagger_overlap: got %0d expected 0", overlap); end
        n_chk++; if (ps_n !== 1)    begin n_fail++; $display("FAIL stagger_period_start: got %0d expected 1", ps_n); end
    endtask

    task automatic test_sleep_reset();
        set_ch(0, 128, M_PWM);
        wait_cnt(20);
        pulse_load();
        n_chk++; if (pend_a !== 1'b1) begin n_fail++; $display("FAIL sleep_pend_before: got %b expected 1", pend_a); end
        wait_cnt(50);
        n_chk++; if (pwm_a !== 4'hF) begin n_fail++; $display("FAIL sleep_pwm_before: got %h expected f", pwm_a); end
        sleep = 1'b1;
        tick();
        n_chk++; if (pwm_a !== 4'h0 || pwm_s !== 4'h0) begin n_fail++; $display("FAIL sleep_pwm_dark: got %h/%h expected 0/0", pwm_a, pwm_s); end
        n_chk++; if (pend_a !== 1'b0) begin n_fail++; $display("FAIL sleep_commit: got %b expected 0", pend_a); end
        n_chk++; if (ps_a !== 1'b0)   begin n_fail++; $display("FAIL sleep_period_start: got %b expected 0", ps_a); end
        set_ch(2, 100, M_PWM);
        load = 1'b1;
        tick();
        load = 1'b0;
        n_chk++; if (pend_a !== 1'b1) begin n_fail++; $display("FAIL sleep_load_accepted: got %b expected 1", pend_a); end
        tick();
        n_chk++; if (pend_a !== 1'b0) begin n_fail++; $display("FAIL sleep_load_commit: got %b expected 0", pend_a); end
        tick();
        sleep = 1'b0;
        tick();
        n_chk++; if (ps_a !== 1'b1 || ps_s !== 1'b1) begin n_fail++; $display("FAIL wake_period_start: got %b%b expected 11", ps_a, ps_s); end
        n_chk++; if (pwm_s !== 4'b0001) begin n_fail++; $display("FAIL wake_stagger_phase: got %b expected 0001", pwm_s); end
        tick();
        n_chk++; if (ps_a !== 1'b0) begin n_fail++; $display("FAIL wake_period_start_width: got %b expected 0", ps_a); end
        measure(1'b0, -1);
        n_chk++; if (hi[0] !== 128) begin n_fail++; $display("FAIL wake_ch0: got %0d expected 128", hi[0]); end
        n_chk++; if (hi[2] !== 100) begin n_fail++; $display("FAIL wake_ch2: got %0d expected 100", hi[2]); end

        set_ch(3, 5, M_PWM);
        wait_cnt(70);
        pulse_load();
        wait_cnt(77);
        n_chk++; if (pwm_a[0] !== 1'b1 || pend_a !== 1'b1) begin n_fail++; $display("FAIL prereset_state: got pwm0=%b pend=%b expected 1/1", pwm_a[0], pend_a); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (pwm_a !== 4'h0 || pwm_s !== 4'h0) begin n_fail++; $display("FAIL async_reset_pwm: got %h/%h expected 0/0", pwm_a, pwm_s); end
        n_chk++; if (pend_a !== 1'b0 || ps_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got pend=%b ps=%b expected 0/0", pend_a, ps_a); end
        tick();
        rst_n = 1'b1;
        measure(1'b0, -1);
        n_chk++; if (hi[0] !== 0 || hi[3] !== 0) begin n_fail++; $display("FAIL reset_discard: got ch0=%0d ch3=%0d expected 0/0", hi[0], hi[3]); end
        n_chk++; if (ps_n !== 1) begin n_fail++; $display("FAIL reset_period_start: got %0d expected 1", ps_n); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_glitch_free();
        test_back_to_back();
        test_stagger();
        test_sleep_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_pwm_controller.md
Name: multi_pwm_controller

Overview:
Parametrised N-channel PWM generator. It drives the LED outputs of the LED controller and is the next generation of the fixed 4-channel, 8-bit PWM block.
- One shared free-running period counter.
- Per-channel mode select: off, on, PWM, inverted PWM.
- Double-buffered duty/mode registers, committed only at period boundaries, so outputs are glitch-free.
- Optional phase stagger between channels to spread LED current peaks.
- Sleep input freezes the counter and forces outputs low.

Parameters:
NUM_CH, 4, number of PWM channels (1..2**WIDTH)
WIDTH, 8, duty/counter width; period = 2**WIDTH cycles
PHASE_STAGGER, 1, 1 = channel i counter offset by i*(2**WIDTH/NUM_CH) (integer division); 0 = all channels aligned

Ports:
clk_pwm  input  1  PWM clock; single clock domain
rst_n  input  1  asynchronous active-low reset
sleep  input  1  1 = low-power: counter held, outputs low
load  input  1  1-cycle strobe: capture duty_in/mode_in into shadow registers
duty_in  input  NUM_CH*WIDTH  channel i duty at [i*WIDTH +: WIDTH]
mode_in  input  2*NUM_CH  channel i mode at [2*i +: 2]: 00 OFF, 01 ON, 10 PWM, 11 INV_PWM
pwm_out  output  NUM_CH  registered per-channel PWM outputs
period_start  output  1  1-cycle pulse, aligned with pwm_out reflecting cnt==0
update_pending  output  1  shadow holds values not yet committed to active

Behaviour:
- Reset (async, rst_n=0) values:
  - cnt=0.
  - Shadow and active duty=0, mode=OFF.
  - pwm_out=0, period_start=0, update_pending=0.
- Counter:
  - cnt (WIDTH bits) increments by 1 each clk_pwm edge while sleep=0.
  - Wraps 2**WIDTH-1 -> 0 with no idle cycle.
- Channel phase:
  - ph_i = (cnt + OFF_i) mod 2**WIDTH.
  - OFF_i = i*(2**WIDTH/NUM_CH) if PHASE_STAGGER=1, else 0.
  - Computed in WIDTH bits; the carry is discarded.
- Compare:
  - raw_i = (ph_i < act_duty_i), unsigned.
  - duty 0 -> never high.
  - duty 2**WIDTH-1 -> high 2**WIDTH-1 of 2**WIDTH cycles. 100% is available only via mode ON.
- Mode mapping: OFF -> 0; ON -> 1; PWM -> raw_i; INV_PWM -> ~raw_i.
- Latency: pwm_out registered. pwm_out at cycle t+1 reflects cnt/active values at cycle t.
- period_start: registered. Equals 1 in the cycle after cnt==0 was sampled with sleep=0.
- Shadow load:
  - load=1 captures duty_in and mode_in into shadow and sets update_pending=1 on the same edge.
  - load while pending overwrites the shadow; last load wins.
- Commit:
  - On the edge where cnt==2**WIDTH-1 and sleep=0, active <= shadow and update_pending <= 0.
  - New values therefore take effect from cnt==0 of the next period.
  - Mid-period loads never alter the current period.
- Simultaneous load and commit (load=1 on the commit edge):
  - Active takes the pre-load shadow contents.
  - Shadow takes the new inputs.
  - update_pending stays 1; the new values commit at the following wrap.
- Sleep:
  - While sleep=1: cnt is held at 0, pwm_out <= 0 and period_start <= 0 on every edge.
  - Loads are still accepted.
  - If update_pending=1, the commit happens on the first edge with sleep=1 (no glitch concern while dark) and pending clears.
- Sleep exit:
  - First edge with sleep=0 samples cnt=0 and advances it to 1.
  - period_start=1 and outputs resume one cycle after sleep falls.
- Reset mid-period: all state returns to reset values immediately. Pending shadow data is discarded.

Test Plan:
1. Reset, NUM_CH=4, WIDTH=8, PHASE_STAGGER=0: load duty0=64 PWM, wait for commit -> pwm_out[0] high exactly 64 of every 256 cycles; period_start pulses every 256 cycles; update_pending high from load until the cnt==255 edge.
2. Boundaries: duty 0/PWM -> constant 0; duty 255/PWM -> low exactly 1 cycle per period; mode ON -> constant 1; duty 64/INV_PWM -> high 192 of 256.
3. Glitch-free update: channel 1 at duty 200; load duty 10 at cnt=100 -> current period still shows 200 high cycles; next period shows 10.
4. Load coincident with commit edge (cnt=255): shadow A pending, load B -> period n+1 uses A, period n+2 uses B; update_pending=1 through period n+1.
5. PHASE_STAGGER=1, all channels duty 64 PWM -> rising edges of ch0..ch3 at cnt+1 = 0, 192, 128, 64; pulses non-overlapping.
6. Sleep at cnt=50 with a pending load -> next cycle pwm_out=0, update_pending=0, cnt held at 0. Deassert sleep -> period_start pulses one cycle later and the new duty is active. Assert rst_n=0 mid-period -> all outputs 0 asynchronously.
